// File: rtl/axist_dual_test_seq.sv
// AVMM sequencer for the AXI-ST dual leader/follower AIB loopback test.
// State table:
//   state        | meaning
//   IDLE         | waiting for i_start
//   WR_DX..WR_DZ | program the three delay registers
//   AXI_RST_SET  | assert the AXI reset (0x50003000 = 1)
//   AXI_RST_WAIT | hold the AXI reset for AXI_RST_HOLD cycles
//   AXI_RST_CLR  | release the AXI reset (0x50003000 = 0)
//   POLL_LINK    | read link status until [3:0] == 4'hF
//   WR_*_CTRL    | start the L2F and F2L packet generators
//   POLL_L2F/F2L | read checker status until bit 3 is set
//   RD_*_DOUT/DIN| eight reads that assemble a 256-bit last-word
//   REPORT       | register the pass results
//   DONE         | sequence finished, results held
//   ERR          | aborted on timeout, abort state held
module axist_dual_test_seq #(
  parameter logic [31:0] DELAY_X      = 32'h0000000C,
  parameter logic [31:0] DELAY_Y      = 32'h00000020,
  parameter logic [31:0] DELAY_Z      = 32'h00001770,
  parameter logic [31:0] PKT_CTRL     = 32'h00000FF5,
  parameter int unsigned AXI_RST_HOLD = 100,
  parameter int unsigned ACC_GAP      = 20,
  parameter logic [31:0] TIMEOUT      = 32'd1048576
) (
  input  logic        mgmt_clk,
  input  logic        mgmt_rst,
  input  logic        i_start,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wrdata,
  output logic        o_wren,
  output logic        o_rden,
  input  logic        i_waitreq,
  input  logic [31:0] i_readdata,
  input  logic        i_readdatavalid,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_l2f_pass,
  output logic        o_f2l_pass,
  output logic        o_pass,
  output logic        o_timeout,
  output logic [4:0]  o_err_state
);

  // Encoding is ordinal so the linear flow advances with state + 1.
  typedef enum logic [4:0] {
    IDLE, WR_DX, WR_DY, WR_DZ, AXI_RST_SET, AXI_RST_WAIT, AXI_RST_CLR,
    POLL_LINK, WR_L2F_CTRL, WR_F2L_CTRL, POLL_L2F, RD_L2F_DOUT, RD_L2F_DIN,
    POLL_F2L, RD_F2L_DOUT, RD_F2L_DIN, REPORT, DONE, ERR
  } state_t;

  typedef enum logic [1:0] {PH_ISSUE, PH_REQ, PH_RDV, PH_GAP} phase_t;

  state_t         state;
  phase_t         phase;
  logic [2:0]     word_cnt;
  logic [15:0]    gap_cnt;
  logic [31:0]    wait_cnt;
  logic [3:0]     poll_nib;
  logic [2:0]     l2f_stat, f2l_stat;
  logic [255:0]   l2f_dout, l2f_din, f2l_dout, f2l_din;

  logic [31:0]    acc_addr, acc_data;
  logic           is_read, is_poll, is_rd_data, counting, adv;
  logic [31:0]    word_ofs;
  logic           l2f_ok, f2l_ok;

  assign word_ofs = {27'd0, word_cnt, 2'b00};

  always_comb begin
    acc_addr = '0;
    acc_data = '0;
    is_read  = 1'b1;
    case (state)
      WR_DX:       begin acc_addr = 32'h50002000; acc_data = DELAY_X;  is_read = 1'b0; end
      WR_DY:       begin acc_addr = 32'h50002004; acc_data = DELAY_Y;  is_read = 1'b0; end
      WR_DZ:       begin acc_addr = 32'h50002008; acc_data = DELAY_Z;  is_read = 1'b0; end
      AXI_RST_SET: begin acc_addr = 32'h50003000; acc_data = 32'd1;    is_read = 1'b0; end
      AXI_RST_CLR: begin acc_addr = 32'h50003000; acc_data = 32'd0;    is_read = 1'b0; end
      WR_L2F_CTRL: begin acc_addr = 32'h50001000; acc_data = PKT_CTRL; is_read = 1'b0; end
      WR_F2L_CTRL: begin acc_addr = 32'h50001008; acc_data = PKT_CTRL; is_read = 1'b0; end
      POLL_LINK:   acc_addr = 32'h50001010;
      POLL_L2F:    acc_addr = 32'h50001004;
      POLL_F2L:    acc_addr = 32'h5000100C;
      RD_L2F_DOUT: acc_addr = 32'h50004100 + word_ofs;
      RD_L2F_DIN:  acc_addr = 32'h50004300 + word_ofs;
      RD_F2L_DOUT: acc_addr = 32'h50005100 + word_ofs;
      RD_F2L_DIN:  acc_addr = 32'h50005300 + word_ofs;
      default:     is_read = 1'b0;
    endcase
  end

  assign is_poll    = (state == POLL_LINK) || (state == POLL_L2F) || (state == POLL_F2L);
  assign is_rd_data = (state == RD_L2F_DOUT) || (state == RD_L2F_DIN) ||
                      (state == RD_F2L_DOUT) || (state == RD_F2L_DIN);
  assign counting   = is_poll || (phase == PH_RDV);

  always_comb begin
    adv = 1'b1;
    if (state == POLL_LINK)                           adv = (poll_nib == 4'hF);
    else if ((state == POLL_L2F) || (state == POLL_F2L)) adv = poll_nib[3];
    else if (is_rd_data)                              adv = (word_cnt == 3'd7);
  end

  assign l2f_ok = (&l2f_stat) && (l2f_dout == l2f_din);
  assign f2l_ok = (&f2l_stat) && (f2l_dout == f2l_din);

  always_ff @(posedge mgmt_clk) begin
    if (mgmt_rst) begin
      state       <= IDLE;
      phase       <= PH_ISSUE;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      wait_cnt    <= '0;
      poll_nib    <= '0;
      l2f_stat    <= '0;
      f2l_stat    <= '0;
      l2f_dout    <= '0;
      l2f_din     <= '0;
      f2l_dout    <= '0;
      f2l_din     <= '0;
      o_wr_addr   <= '0;
      o_wrdata    <= '0;
      o_wren      <= 1'b0;
      o_rden      <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_l2f_pass  <= 1'b0;
      o_f2l_pass  <= 1'b0;
      o_pass      <= 1'b0;
      o_timeout   <= 1'b0;
      o_err_state <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            state       <= WR_DX;
            phase       <= PH_ISSUE;
            word_cnt    <= '0;
            wait_cnt    <= '0;
            o_busy      <= 1'b1;
            o_done      <= 1'b0;
            o_l2f_pass  <= 1'b0;
            o_f2l_pass  <= 1'b0;
            o_pass      <= 1'b0;
            o_timeout   <= 1'b0;
            o_err_state <= '0;
          end
        end
        AXI_RST_WAIT: begin
          if (gap_cnt == '0) begin
            state    <= AXI_RST_CLR;
            phase    <= PH_ISSUE;
            wait_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end
        REPORT: begin
          o_l2f_pass <= l2f_ok;
          o_f2l_pass <= f2l_ok;
          o_pass     <= l2f_ok && f2l_ok;
          o_done     <= 1'b1;
          o_busy     <= 1'b0;
          state      <= DONE;
        end
        default: begin
          if (counting && (wait_cnt == TIMEOUT - 32'd1)) begin
            state       <= ERR;
            phase       <= PH_ISSUE;
            o_wren      <= 1'b0;
            o_rden      <= 1'b0;
            o_timeout   <= 1'b1;
            o_err_state <= state;
            o_done      <= 1'b1;
            o_busy      <= 1'b0;
          end else begin
            if (counting) wait_cnt <= wait_cnt + 32'd1;
            case (phase)
              PH_ISSUE: begin
                o_wr_addr <= acc_addr;
                o_wrdata  <= acc_data;
                o_wren    <= !is_read;
                o_rden    <= is_read;
                phase     <= PH_REQ;
              end
              PH_REQ: begin
                if (!i_waitreq) begin
                  o_wren <= 1'b0;
                  o_rden <= 1'b0;
                  if (o_rden) begin
                    phase <= PH_RDV;
                  end else begin
                    phase   <= PH_GAP;
                    gap_cnt <= 16'(ACC_GAP - 1);
                  end
                end
              end
              PH_RDV: begin
                if (i_readdatavalid) begin
                  poll_nib <= i_readdata[3:0];
                  case (state)
                    POLL_L2F:    l2f_stat <= {i_readdata[3], i_readdata[1:0]};
                    POLL_F2L:    f2l_stat <= {i_readdata[3], i_readdata[1:0]};
                    RD_L2F_DOUT: l2f_dout <= {i_readdata, l2f_dout[255:32]};
                    RD_L2F_DIN:  l2f_din  <= {i_readdata, l2f_din[255:32]};
                    RD_F2L_DOUT: f2l_dout <= {i_readdata, f2l_dout[255:32]};
                    RD_F2L_DIN:  f2l_din  <= {i_readdata, f2l_din[255:32]};
                    default: ;
                  endcase
                  phase   <= PH_GAP;
                  gap_cnt <= 16'(ACC_GAP - 1);
                end
              end
              default: begin
                if (gap_cnt != '0) begin
                  gap_cnt <= gap_cnt - 16'd1;
                end else begin
                  phase <= PH_ISSUE;
                  if (is_rd_data) word_cnt <= word_cnt + 3'd1;
                  if (adv) begin
                    state    <= state_t'(state + 5'd1);
                    wait_cnt <= '0;
                    if (state == AXI_RST_SET) gap_cnt <= 16'(AXI_RST_HOLD - 1);
                  end
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule
